score_tx_sender: RTL and testbench
==================================

SCORE_TX_SENDER -- requirements
Module: score_tx_sender

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, power-of-two score buffer depth (≥ 4).
REQ-002 Parameter SCORE_WIDTH, default 16, similarity score width.
REQ-003 CLK  in  1  sole clock; all logic on rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 cfg_valid_i  in  1  one-cycle strobe loading the expected score count.
REQ-006 cfg_num_i  in  18  number of scores N for the next transaction.
REQ-007 score_valid_i  in  1  score present.
REQ-008 score_i  in  SCORE_WIDTH  signed similarity score.
REQ-009 score_ready_o  out  1  FIFO can accept (count < FIFO_DEPTH).
REQ-010 overflow_o  out  1  sticky: a score was offered while score_ready_o was low.
REQ-011 done_o  out  1  one-cycle pulse at transaction end.
REQ-012 CHNL_TX  out  1; CHNL_TX_ACK  in  1; CHNL_TX_LAST  out  1; CHNL_TX_LEN  out  32 (32-bit words); CHNL_TX_OFF  out  31; CHNL_TX_DATA  out  128; CHNL_TX_DATA_VALID  out  1; CHNL_TX_DATA_REN  in  1.

Function
REQ-013 The block SHALL push score_i into the FIFO when score_valid_i and score_ready_o are both high, in any state.
REQ-014 The FIFO SHALL be first-word-fall-through; push and pop in the same cycle SHALL leave count unchanged.
REQ-015 A score offered while full SHALL be dropped and SHALL set overflow_o until reset.
REQ-016 FSM states: IDLE, WAIT, REQ, SEND, FIN.
REQ-017 IDLE: cfg_valid_i with cfg_num_i ≠ 0 SHALL latch N and the beat count and go to WAIT; with cfg_num_i = 0 it SHALL go to FIN.
REQ-018 WAIT: go to REQ when the FIFO is non-empty.
REQ-019 REQ: CHNL_TX = 1 and CHNL_TX_LEN = 4 × total beats, held stable; go to SEND on the first cycle CHNL_TX_ACK is sampled high.
REQ-020 SEND: CHNL_TX SHALL stay 1.
REQ-021 SEND: CHNL_TX_DATA_VALID SHALL equal the current beat being available (FIFO non-empty for score beats).
REQ-022 SEND: a beat is accepted when CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN.
REQ-023 Score beat data SHALL be {112'b0, score}; data bits above [15:0] SHALL be zero.
REQ-024 When the last beat is accepted, the FSM SHALL go to FIN, and CHNL_TX SHALL deassert the next cycle.
REQ-025 FIN SHALL assert done_o for one cycle and return to IDLE.
REQ-026 CHNL_TX_LAST SHALL be constant 1 and CHNL_TX_OFF constant 0.
REQ-027 cfg_valid_i outside IDLE SHALL be ignored.
REQ-028 Scores beyond N SHALL remain buffered for the next transaction.
REQ-029 DATA_REN high while DATA_VALID is low SHALL have no effect; FIFO underflow SHALL be impossible.

Reset
REQ-030 On RST the FSM SHALL go to IDLE and the FIFO SHALL be emptied.
REQ-031 On RST overflow_o, done_o, CHNL_TX, CHNL_TX_DATA_VALID, CHNL_TX_LEN and CHNL_TX_DATA SHALL all be 0; score_ready_o SHALL be 1.
REQ-032 RST mid-transaction SHALL abort it with no done_o; the next cfg_valid_i SHALL start cleanly.

Configuration
REQ-033 Macro TX_CYCLE_COUNT_EN defined: a 32-bit counter SHALL clear on cfg accept, increment every cycle (saturating at 0xFFFFFFFF) and freeze when the last score beat is accepted.
REQ-034 With TX_CYCLE_COUNT_EN, one extra final beat {96'b0, count} SHALL be sent and total beats = N+1 (LEN = 4N+4).
REQ-035 Without TX_CYCLE_COUNT_EN, total beats = N (LEN = 4N), and the counter logic SHALL be absent.

Verification
REQ-036 N=3, scores 0x0012, 0xFFF0, 0x0005 preloaded, ACK 1 cycle, REN always 1 -> LEN=12 (16 with macro); three beats in order; done_o pulse; CHNL_TX low after last beat.
REQ-037 N=9, scores arriving every 40 cycles, REN randomly toggled -> DATA_VALID only when a score is buffered; all 9 scores received in order; no extra beats.
REQ-038 FIFO_DEPTH=16, 17 scores pushed in IDLE -> score_ready_o low after 16; 17th dropped; overflow_o=1 and sticky.
REQ-039 cfg_num_i=0 -> CHNL_TX never asserts; done_o pulses 2 cycles after cfg_valid_i.
REQ-040 RST pulse mid-SEND after 2 of 5 beats -> all outputs at reset values; new N=1 transaction completes with LEN=4.
REQ-041 With macro, ACK delayed 10 cycles, N=2 -> final beat [31:0] equals the cycles from cfg accept to second score acceptance.

Source files
------------

// File: rtl/score_tx_sender.sv
// score_tx_sender: buffers signed similarity scores in a first-word-fall-through
// FIFO and sends N of them per transaction over a 128-bit TX channel, one score
// per beat. Each beat carries the score zero-extended to 128 bits.
// Build option TX_CYCLE_COUNT_EN: appends one extra beat that carries a 32-bit
// cycle count. The count runs from cfg accept to acceptance of the last score beat.
module score_tx_sender #(
    parameter int FIFO_DEPTH  = 16,
    parameter int SCORE_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   cfg_valid_i,
    input  logic [17:0]            cfg_num_i,
    input  logic                   score_valid_i,
    input  logic [SCORE_WIDTH-1:0] score_i,
    output logic                   score_ready_o,
    output logic                   overflow_o,
    output logic                   done_o,
    output logic                   CHNL_TX,
    input  logic                   CHNL_TX_ACK,
    output logic                   CHNL_TX_LAST,
    output logic [31:0]            CHNL_TX_LEN,
    output logic [30:0]            CHNL_TX_OFF,
    output logic [127:0]           CHNL_TX_DATA,
    output logic                   CHNL_TX_DATA_VALID,
    input  logic                   CHNL_TX_DATA_REN
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef TX_CYCLE_COUNT_EN
    localparam logic [18:0] EXTRA_BEATS = 19'd1;
`else
    localparam logic [18:0] EXTRA_BEATS = 19'd0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_SEND, S_FIN} state_t;
    state_t state, state_nxt;

    logic [SCORE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [AW:0]            count;
    logic                   fifo_empty, push, pop;
    logic [SCORE_WIDTH-1:0] head;

    logic [17:0] n_reg;
    logic [18:0] total_beats, total_new, beat_idx;
    logic [31:0] len_reg;
    logic        cfg_accept, beat_acc, is_score_beat, last_beat;

    assign fifo_empty    = (count == '0);
    assign score_ready_o = (count < (AW+1)'(FIFO_DEPTH));
    assign push          = score_valid_i & score_ready_o;
    assign head          = mem[rd_ptr];

    assign cfg_accept    = (state == S_IDLE) & cfg_valid_i;
    assign total_new     = {1'b0, cfg_num_i} + EXTRA_BEATS;
    assign is_score_beat = (beat_idx < {1'b0, n_reg});
    assign last_beat     = (beat_idx == total_beats - 19'd1);
    assign beat_acc      = CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN;
    // DATA_VALID requires a non-empty FIFO for score beats, so pop never underflows
    assign pop           = beat_acc & is_score_beat;

    assign CHNL_TX_LAST  = 1'b1;
    assign CHNL_TX_OFF   = '0;
    assign CHNL_TX_LEN   = len_reg;

    // FIFO storage write (no reset needed on the data array)
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= score_i;
    end

    // FIFO pointers and occupancy; simultaneous push/pop keeps count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // sticky overflow: any score offered while the FIFO is full
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                                 overflow_o <= 1'b0;
        else if (score_valid_i & ~score_ready_o) overflow_o <= 1'b1;
    end

    // transaction length/beat bookkeeping latched on cfg accept
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            n_reg       <= '0;
            total_beats <= '0;
            len_reg     <= '0;
            beat_idx    <= '0;
        end else if (cfg_accept && cfg_num_i != '0) begin
            n_reg       <= cfg_num_i;
            total_beats <= total_new;
            len_reg     <= {11'b0, total_new, 2'b00};
            beat_idx    <= '0;
        end else if (beat_acc) begin
            beat_idx    <= beat_idx + 19'd1;
        end
    end

`ifdef TX_CYCLE_COUNT_EN
    logic [31:0] cyc_cnt;
    logic        cnt_frozen;

    // cycle counter: clears on cfg accept, saturates, freezes after last score beat
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc_cnt    <= '0;
            cnt_frozen <= 1'b0;
        end else if (cfg_accept) begin
            cyc_cnt    <= '0;
            cnt_frozen <= 1'b0;
        end else begin
            if (!cnt_frozen && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
            if (pop && beat_idx == {1'b0, n_reg} - 19'd1) cnt_frozen <= 1'b1;
        end
    end
`endif

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cfg_valid_i) state_nxt = (cfg_num_i != '0) ? S_WAIT : S_FIN;
            S_WAIT: if (!fifo_empty) state_nxt = S_REQ;
            S_REQ:  if (CHNL_TX_ACK) state_nxt = S_SEND;
            S_SEND: if (beat_acc && last_beat) state_nxt = S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // channel outputs decoded from state and current beat
    always_comb begin
        CHNL_TX            = 1'b0;
        CHNL_TX_DATA_VALID = 1'b0;
        CHNL_TX_DATA       = '0;
        case (state)
            S_REQ: CHNL_TX = 1'b1;
            S_SEND: begin
                CHNL_TX = 1'b1;
                if (is_score_beat) begin
                    CHNL_TX_DATA_VALID = ~fifo_empty;
                    CHNL_TX_DATA       = {{(128-SCORE_WIDTH){1'b0}}, head};
                end else begin
`ifdef TX_CYCLE_COUNT_EN
                    CHNL_TX_DATA_VALID = 1'b1;
                    CHNL_TX_DATA       = {96'b0, cyc_cnt};
`endif
                end
            end
            default: ;
        endcase
    end

    // done pulse one cycle after FIN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) done_o <= 1'b0;
        else     done_o <= (state == S_FIN);
    end

endmodule

// File: tb/tb_score_tx_sender.sv
// Self-checking bench for score_tx_sender: a table of transactions plus
// hand-written overflow, zero-length and mid-transfer reset sequences.
module tb_score_tx_sender;

`ifdef TX_CYCLE_COUNT_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         cfg_valid_i = 1'b0;
    logic [17:0]  cfg_num_i = '0;
    logic         score_valid_i = 1'b0;
    logic [15:0]  score_i = '0;
    logic         score_ready_o, overflow_o, done_o;
    logic         CHNL_TX, CHNL_TX_LAST, CHNL_TX_DATA_VALID;
    logic         CHNL_TX_ACK = 1'b0;
    logic         CHNL_TX_DATA_REN = 1'b0;
    logic [31:0]  CHNL_TX_LEN;
    logic [30:0]  CHNL_TX_OFF;
    logic [127:0] CHNL_TX_DATA;

    score_tx_sender #(.FIFO_DEPTH(16), .SCORE_WIDTH(16)) dut (
        .CLK(CLK), .RST(RST),
        .cfg_valid_i(cfg_valid_i), .cfg_num_i(cfg_num_i),
        .score_valid_i(score_valid_i), .score_i(score_i),
        .score_ready_o(score_ready_o), .overflow_o(overflow_o), .done_o(done_o),
        .CHNL_TX(CHNL_TX), .CHNL_TX_ACK(CHNL_TX_ACK), .CHNL_TX_LAST(CHNL_TX_LAST),
        .CHNL_TX_LEN(CHNL_TX_LEN), .CHNL_TX_OFF(CHNL_TX_OFF),
        .CHNL_TX_DATA(CHNL_TX_DATA), .CHNL_TX_DATA_VALID(CHNL_TX_DATA_VALID),
        .CHNL_TX_DATA_REN(CHNL_TX_DATA_REN)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          nvec = 0;
    int          nfail = 0;
    logic [127:0] exp_q[$];
    int          scores_left = 0;
    bit          in_send = 0;
    bit          chk_tx_low = 0;
    int          ack_delay_v = 0;
    bit          ren_rand_v = 0;
    int          ack_wait = 0;
    bit          ack_done = 0;
    int unsigned cfg_cyc = 0;
    int unsigned last_cyc = 0;

    typedef struct {
        int          n;
        int          n_feed;
        bit          preload;
        int          gap;
        int          ack_delay;
        bit          ren_rand;
        bit          fixed;
        bit          poke_cfg;
        logic [31:0] exp_len;
    } txn_t;

    txn_t        tbl[4];
    logic [15:0] fixed_sc[3];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] score_for(input bit fixed, input int unsigned i);
        if (fixed) return fixed_sc[i % 3];
        return 16'($urandom);
    endfunction

    // ACK responder: one-cycle ACK after ack_delay_v cycles of CHNL_TX
    initial begin
        forever begin
            @(posedge CLK);
            if (CHNL_TX_ACK) in_send = 1;
            #1;
            CHNL_TX_ACK = 1'b0;
            if (!CHNL_TX) begin
                ack_done = 0;
                ack_wait = 0;
            end else if (!ack_done) begin
                if (ack_wait >= ack_delay_v) begin
                    CHNL_TX_ACK = 1'b1;
                    ack_done = 1;
                end else begin
                    ack_wait++;
                end
            end
        end
    end

    // REN driver
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            CHNL_TX_DATA_REN = ren_rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // beat monitor / scoreboard consumer
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_tx_low) begin
                check("tx_low_after_last", CHNL_TX, 0);
                chk_tx_low = 0;
            end
            if (!CHNL_TX) in_send = 0;
            if (in_send && !RST) begin
                if (scores_left > 0)
                    check("data_valid", CHNL_TX_DATA_VALID, (exp_q.size() != 0));
                else
                    check("cnt_beat_valid", CHNL_TX_DATA_VALID, 1);
                if (CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN) begin
                    if (scores_left > 0) begin
                        if (exp_q.size() == 0) begin
                            check("beat_without_score", 1, 0);
                        end else begin
                            check("beat_data", CHNL_TX_DATA, exp_q.pop_front());
                        end
                        scores_left--;
                        if (scores_left == 0) begin
                            last_cyc = cyc + 1;
                            if (EXTRA == 0) chk_tx_low = 1;
                        end
                    end else begin
                        if (EXTRA == 0) begin
                            check("extra_beat", 1, 0);
                        end else begin
                            check("cnt_beat_data", CHNL_TX_DATA, {96'b0, 32'(last_cyc - cfg_cyc)});
                            chk_tx_low = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic push_score(input logic [15:0] v);
        bit ok;
        @(posedge CLK);
        #1;
        score_valid_i = 1'b1;
        score_i = v;
        ok = score_ready_o;
        @(posedge CLK);
        #1;
        score_valid_i = 1'b0;
        if (ok) exp_q.push_back({112'b0, v});
    endtask

    task automatic wait_done();
        int w = 0;
        while (!done_o && w < 3000) begin
            @(negedge CLK);
            w++;
        end
        check("done_pulse", done_o, 1);
        @(negedge CLK);
        check("done_one_cycle", done_o, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    task automatic run_txn(input txn_t t);
        ack_delay_v = t.ack_delay;
        ren_rand_v  = t.ren_rand;
        if (t.preload)
            for (int unsigned i = 0; i < t.n_feed; i++) push_score(score_for(t.fixed, i));
        @(posedge CLK);
        #1;
        cfg_valid_i = 1'b1;
        cfg_num_i   = 18'(t.n);
        cfg_cyc     = cyc + 1;
        scores_left = t.n;
        @(posedge CLK);
        #1;
        cfg_valid_i = 1'b0;
        fork
            begin
                if (!t.preload)
                    for (int unsigned i = 0; i < t.n_feed; i++) begin
                        repeat (t.gap) @(posedge CLK);
                        push_score(score_for(t.fixed, i));
                    end
            end
            begin
                int w = 0;
                while (!CHNL_TX && w < 2000) begin
                    @(negedge CLK);
                    w++;
                end
                check("req_tx", CHNL_TX, 1);
                check("req_len", CHNL_TX_LEN, t.exp_len);
                if (t.poke_cfg) begin
                    @(posedge CLK);
                    #1;
                    cfg_valid_i = 1'b1;
                    cfg_num_i   = 18'd7;
                    @(posedge CLK);
                    #1;
                    cfg_valid_i = 1'b0;
                    @(negedge CLK);
                    check("len_after_ignored_cfg", CHNL_TX_LEN, t.exp_len);
                end
            end
        join
        wait_done();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, score_ready_o, 1);
        check({tag, "_ovf"},   overflow_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_tx"},    CHNL_TX, 0);
        check({tag, "_valid"}, CHNL_TX_DATA_VALID, 0);
        check({tag, "_len"},   CHNL_TX_LEN, 0);
        check({tag, "_data"},  CHNL_TX_DATA, 0);
        check({tag, "_last"},  CHNL_TX_LAST, 1);
        check({tag, "_off"},   CHNL_TX_OFF, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   w;

        fixed_sc[0] = 16'h0012;
        fixed_sc[1] = 16'hFFF0;
        fixed_sc[2] = 16'h0005;
        //          n  feed pre gap ack rnd fix poke  len
        tbl[0] = '{3, 3, 1, 0,  0,  0, 1, 0, 32'(12 + 4 * EXTRA)};
        tbl[1] = '{9, 9, 0, 40, 2,  1, 0, 0, 32'(36 + 4 * EXTRA)};
        tbl[2] = '{2, 2, 0, 3,  10, 0, 0, 0, 32'(8  + 4 * EXTRA)};
        tbl[3] = '{5, 5, 1, 0,  0,  1, 0, 1, 32'(20 + 4 * EXTRA)};

        #2;
        check_reset_vals("por");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int unsigned k = 0; k < 4; k++) run_txn(tbl[k]);

        // overflow: 17 pushes into a 16-deep FIFO while idle
        for (int unsigned i = 0; i < 16; i++) push_score(16'($urandom));
        check("ready_when_full", score_ready_o, 0);
        check("ovf_before_drop", overflow_o, 0);
        push_score(16'hDEAD);
        check("ovf_set", overflow_o, 1);
        check("fifo_kept_16", exp_q.size(), 16);
        t = '{16, 0, 1, 0, 0, 0, 0, 0, 32'(64 + 4 * EXTRA)};
        run_txn(t);
        check("ovf_sticky", overflow_o, 1);

        // zero-length transaction
        @(posedge CLK);
        #1;
        cfg_valid_i = 1'b1;
        cfg_num_i   = 18'd0;
        @(posedge CLK);
        #1;
        cfg_valid_i = 1'b0;
        check("zero_done_c1", done_o, 0);
        check("zero_tx_c1", CHNL_TX, 0);
        @(posedge CLK);
        #1;
        check("zero_done_c2", done_o, 1);
        check("zero_tx_c2", CHNL_TX, 0);
        @(posedge CLK);
        #1;
        check("zero_done_c3", done_o, 0);
        check("zero_tx_c3", CHNL_TX, 0);

        // reset after 2 of 5 beats
        ack_delay_v = 0;
        ren_rand_v  = 0;
        for (int unsigned i = 0; i < 5; i++) push_score(16'($urandom));
        @(posedge CLK);
        #1;
        cfg_valid_i = 1'b1;
        cfg_num_i   = 18'd5;
        cfg_cyc     = cyc + 1;
        scores_left = 5;
        @(posedge CLK);
        #1;
        cfg_valid_i = 1'b0;
        w = 0;
        do begin
            @(posedge CLK);
            #1;
            w++;
        end while (scores_left > 3 && w < 500);
        check("two_beats_sent", scores_left, 3);
        RST = 1'b1;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        scores_left = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        w = 0;
        repeat (4) begin
            @(negedge CLK);
            if (done_o || CHNL_TX) w++;
        end
        check("no_done_after_abort", w, 0);
        t = '{1, 1, 1, 0, 0, 0, 0, 0, 32'(4 + 4 * EXTRA)};
        run_txn(t);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
